// File: rtl/axi_write_master_q.sv
`default_nettype none
// ============================================================================
// Module : axi_write_master_q
// Brief  : AXI3 write master fed by command and data FIFOs. Issues AW only once
//          the whole burst is buffered and returns B responses tagged by ID.
// Rev    : 1.0 - initial release
// ============================================================================
module axi_write_master_q #(
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int CMD_DEPTH  = 8,
  parameter int DATA_DEPTH = 64,
  parameter int MAX_OUTS   = 4
) (
  input  logic                devclock,
  input  logic                ARESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [31:0]         cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,
  output logic                resp_valid,
  output logic [ID_W-1:0]     resp_id,
  output logic [1:0]          resp_code,
  output logic [ID_W-1:0]     AWID,
  output logic [31:0]         AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic [1:0]          AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ID_W-1:0]     WID,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CAW    = $clog2(CMD_DEPTH);
  localparam int DAW    = $clog2(DATA_DEPTH);
  localparam int DCW    = DAW + 1;
  localparam int CMD_W  = ID_W + 32 + 4 + 3 + 2;
  localparam int DAT_W  = DATA_W + STRB_W;
  localparam int IQW    = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;

  localparam logic [3:0]     c_max_outs = 4'(MAX_OUTS);
  localparam logic [IQW-1:0] c_iq_last  = IQW'(MAX_OUTS - 1);

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0] r_cmd_mem [CMD_DEPTH];
  logic [CAW:0]     r_cmd_wr, r_cmd_rd;
  logic             w_cmd_empty, w_cmd_full, w_cmd_push;
  logic [ID_W-1:0]  w_h_id;
  logic [31:0]      w_h_addr;
  logic [3:0]       w_h_len;
  logic [2:0]       w_h_size;
  logic [1:0]       w_h_burst;

  assign w_cmd_empty = (r_cmd_wr == r_cmd_rd);
  assign w_cmd_full  = (r_cmd_wr[CAW] != r_cmd_rd[CAW]) &&
                       (r_cmd_wr[CAW-1:0] == r_cmd_rd[CAW-1:0]);
  assign cmd_ready   = !w_cmd_full;
  assign w_cmd_push  = cmd_valid && cmd_ready;
  assign {w_h_id, w_h_addr, w_h_len, w_h_size, w_h_burst} = r_cmd_mem[r_cmd_rd[CAW-1:0]];

  always_ff @(posedge devclock) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wr[CAW-1:0]] <= {cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst};
  end

  // ---------------- data FIFO ----------------
  logic [DAT_W-1:0] r_dat_mem [DATA_DEPTH];
  logic [DAW:0]     r_dat_wr, r_dat_rd;
  logic             w_dat_full, w_dat_push;
  logic [DCW-1:0]   w_dat_count;

  assign w_dat_full  = (r_dat_wr[DAW] != r_dat_rd[DAW]) &&
                       (r_dat_wr[DAW-1:0] == r_dat_rd[DAW-1:0]);
  assign wd_ready    = !w_dat_full;
  assign w_dat_push  = wd_valid && wd_ready;
  assign w_dat_count = r_dat_wr - r_dat_rd;
  assign {WDATA, WSTRB} = r_dat_mem[r_dat_rd[DAW-1:0]];

  always_ff @(posedge devclock) begin
    if (w_dat_push) r_dat_mem[r_dat_wr[DAW-1:0]] <= {wd_data, wd_strb};
  end

  // ---------------- AW issue ----------------
  logic [DCW-1:0] r_pend;
  logic [DCW-1:0] w_avail, w_need;
  logic [3:0]     r_outs;
  logic           w_aw_hs, w_w_hs, w_b_hs, w_last_hs;

  // Beats already promised to accepted bursts are not available for new AWs.
  assign w_avail = w_dat_count - r_pend;
  assign w_need  = DCW'(w_h_len) + DCW'(1);

  assign AWVALID = !w_cmd_empty && (r_outs < c_max_outs) && (w_avail >= w_need);
  assign AWID    = w_h_id;
  assign AWADDR  = w_h_addr;
  assign AWLEN   = w_h_len;
  assign AWSIZE  = w_h_size;
  assign AWBURST = w_h_burst;
  assign AWLOCK  = 2'b00;
  assign AWCACHE = 4'b0000;
  assign AWPROT  = 3'b000;
  assign w_aw_hs = AWVALID && AWREADY;

  // ---------------- issue queue (AW order -> W order) ----------------
  logic [ID_W-1:0] r_iq_id  [MAX_OUTS];
  logic [3:0]      r_iq_len [MAX_OUTS];
  logic [IQW-1:0]  r_iq_wr, r_iq_rd;
  logic [3:0]      r_iq_cnt;
  logic [3:0]      r_beat;

  assign WVALID    = (r_iq_cnt != 4'd0);
  assign WID       = r_iq_id[r_iq_rd];
  assign WLAST     = WVALID && (r_beat == r_iq_len[r_iq_rd]);
  assign w_w_hs    = WVALID && WREADY;
  assign w_last_hs = w_w_hs && WLAST;

  assign BREADY    = (r_outs != 4'd0);
  assign w_b_hs    = BVALID && BREADY;

  always_ff @(posedge devclock) begin
    if (w_aw_hs) begin
      r_iq_id[r_iq_wr]  <= w_h_id;
      r_iq_len[r_iq_wr] <= w_h_len;
    end
  end

  always_ff @(posedge devclock) begin
    if (!ARESETn) begin
      r_cmd_wr    <= '0;
      r_cmd_rd    <= '0;
      r_dat_wr    <= '0;
      r_dat_rd    <= '0;
      r_pend      <= '0;
      r_outs      <= 4'd0;
      r_iq_wr     <= '0;
      r_iq_rd     <= '0;
      r_iq_cnt    <= 4'd0;
      r_beat      <= 4'd0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_code   <= 2'b00;
    end else begin
      if (w_cmd_push) r_cmd_wr <= r_cmd_wr + 1'b1;
      if (w_aw_hs)    r_cmd_rd <= r_cmd_rd + 1'b1;
      if (w_dat_push) r_dat_wr <= r_dat_wr + 1'b1;
      if (w_w_hs)     r_dat_rd <= r_dat_rd + 1'b1;

      r_pend <= r_pend + (w_aw_hs ? w_need : '0) - (w_w_hs ? DCW'(1) : '0);

      case ({w_aw_hs, w_b_hs})
        2'b10:   r_outs <= r_outs + 4'd1;
        2'b01:   r_outs <= r_outs - 4'd1;
        default: r_outs <= r_outs;
      endcase

      if (w_aw_hs)   r_iq_wr <= (r_iq_wr == c_iq_last) ? '0 : r_iq_wr + 1'b1;
      if (w_last_hs) r_iq_rd <= (r_iq_rd == c_iq_last) ? '0 : r_iq_rd + 1'b1;
      case ({w_aw_hs, w_last_hs})
        2'b10:   r_iq_cnt <= r_iq_cnt + 4'd1;
        2'b01:   r_iq_cnt <= r_iq_cnt - 4'd1;
        default: r_iq_cnt <= r_iq_cnt;
      endcase

      if (w_w_hs) r_beat <= WLAST ? 4'd0 : r_beat + 4'd1;

      resp_valid <= w_b_hs;
      if (w_b_hs) begin
        resp_id   <= BID;
        resp_code <= BRESP;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_master_q.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_write_master_q
// Brief  : Directed bench for axi_write_master_q with a reactive AXI slave.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_axi_write_master_q;

  logic        devclock = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        resp_valid;
  logic [3:0]  resp_id;
  logic [1:0]  resp_code;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST, AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic        AWVALID, AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  axi_write_master_q dut (
    .devclock(devclock), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_code(resp_code),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 devclock = ~devclock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int aw_mode = 0;      // 0 always ready, 1 random, 2 never
  int w_mode = 0;       // 0 always ready, 1 random
  int w_budget = 1000;
  int b_budget = 1000;
  bit b_force = 1'b0;
  logic [1:0] b_resp_val = 2'b00;
  int aw_hs_cyc = 0;
  int b_hs_cyc = 0;

  typedef struct { logic [3:0] id; logic [31:0] addr; logic [3:0] len; } aw_rec_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [3:0] strb; logic last; } w_rec_t;
  aw_rec_t    aw_log[$];
  w_rec_t     w_log[$];
  logic [3:0] b_pend[$];
  logic [5:0] resp_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge devclock);
    #1;
  endtask

  // Reactive AXI slave: logs handshakes at negedge, drives readies after posedge.
  initial begin
    logic        aw_wait, w_wait;
    logic [44:0] aw_prev;
    logic [40:0] w_prev;
    aw_wait = 1'b0; w_wait = 1'b0; aw_prev = '0; w_prev = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BID = 4'd0; BRESP = 2'b00;
    forever begin
      @(negedge devclock);
      if (ARESETn) begin
        if (aw_wait) check("aw_stable", {AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST}, {1'b1, aw_prev});
        if (w_wait)  check("w_stable", {WVALID, WID, WDATA, WSTRB, WLAST}, {1'b1, w_prev});
        aw_wait = AWVALID && !AWREADY;
        w_wait  = WVALID && !WREADY;
        aw_prev = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
        w_prev  = {WID, WDATA, WSTRB, WLAST};
        if (AWVALID && AWREADY) begin
          aw_log.push_back('{AWID, AWADDR, AWLEN});
          aw_hs_cyc = cyc;
        end
        if (WVALID && WREADY) begin
          w_log.push_back('{WID, WDATA, WSTRB, WLAST});
          w_budget--;
          if (WLAST) b_pend.push_back(WID);
        end
        if (BVALID && BREADY) begin
          if (b_pend.size() > 0) void'(b_pend.pop_front());
          b_budget--;
          b_hs_cyc = cyc;
        end
        if (resp_valid) resp_log.push_back({resp_id, resp_code});
      end else begin
        aw_wait = 1'b0;
        w_wait  = 1'b0;
        b_pend.delete();
      end
      @(posedge devclock);
      cyc++;
      #1;
      AWREADY = (aw_mode == 0) ? 1'b1 : (aw_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      WREADY  = (w_budget > 0) && ((w_mode == 0) || ($urandom_range(0, 1) == 1));
      if (b_force) begin
        BVALID = 1'b1; BID = 4'd9; BRESP = 2'b10;
      end else if (b_pend.size() > 0 && b_budget > 0) begin
        BVALID = 1'b1; BID = b_pend[0]; BRESP = b_resp_val;
      end else begin
        BVALID = 1'b0;
      end
    end
  end

  task automatic push_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = len;
    cmd_size = 3'd2; cmd_burst = 2'd1;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (n >= 200) check("cmd_push_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_beat(input logic [31:0] data, input logic [3:0] strb);
    int n;
    n = 0;
    wd_valid = 1'b1; wd_data = data; wd_strb = strb;
    while (!wd_ready && n < 200) begin tick(); n++; end
    if (n >= 200) check("wd_push_timeout", 0, 1);
    tick();
    wd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target, input string name);
    int n;
    n = 0;
    while (resp_log.size() < target && n < 400) begin tick(); n++; end
    check(name, resp_log.size() >= target, 1);
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] base;
    logic [1:0]  bresp;
    int          exp_beats;
    logic [31:0] exp_last_data;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   r0, w0, a0, n, high;
    logic [31:0] exp_data;

    vecs[0] = '{4'd3,  32'h1000, 4'd3,  32'hA0, 2'd0, 4,  32'hA3};
    vecs[1] = '{4'd5,  32'h2000, 4'd0,  32'h11, 2'd2, 1,  32'h11};
    vecs[2] = '{4'd15, 32'h3004, 4'd7,  32'h50, 2'd1, 8,  32'h57};
    vecs[3] = '{4'd0,  32'h0040, 4'd15, 32'hC0, 2'd3, 16, 32'hCF};

    ARESETn = 1'b0;
    cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
    repeat (3) tick();
    check("rst_awvalid", AWVALID, 0);
    check("rst_wvalid", WVALID, 0);
    check("rst_wlast", WLAST, 0);
    check("rst_bready", BREADY, 0);
    check("rst_resp", {resp_valid, resp_id, resp_code}, 0);
    check("rst_ready", {cmd_ready, wd_ready}, 2'b11);
    check("rst_aw_const", {AWLOCK, AWCACHE, AWPROT}, 0);
    ARESETn = 1'b1;
    tick();

    // Single bursts from the vector table
    foreach (vecs[k]) begin
      r0 = resp_log.size(); w0 = w_log.size(); a0 = aw_log.size();
      b_resp_val = vecs[k].bresp;
      push_cmd(vecs[k].id, vecs[k].addr, vecs[k].len);
      for (int i = 0; i <= int'(vecs[k].len); i++) begin
        check("vec_aw_early", AWVALID, 0);
        push_beat(vecs[k].base + 32'(i), ~4'(i));
      end
      check("vec_aw_ready", AWVALID, 1);
      wait_resp(r0 + 1, "vec_resp_timeout");
      check("vec_aw_payload", {aw_log[a0].id, aw_log[a0].addr, aw_log[a0].len},
            {vecs[k].id, vecs[k].addr, vecs[k].len});
      check("vec_beats", w_log.size() - w0, vecs[k].exp_beats);
      for (int i = 0; i < vecs[k].exp_beats && (w0 + i) < w_log.size(); i++)
        check("vec_beat", {w_log[w0+i].id, w_log[w0+i].last, w_log[w0+i].strb, w_log[w0+i].data},
              {vecs[k].id, (i == vecs[k].exp_beats - 1), ~4'(i), vecs[k].base + 32'(i)});
      check("vec_last_data", w_log[w_log.size()-1].data, vecs[k].exp_last_data);
      check("vec_resp", resp_log[r0], {vecs[k].id, vecs[k].bresp});
    end

    // AW held until the whole burst is buffered
    r0 = resp_log.size();
    b_resp_val = 2'd0;
    push_cmd(4'd7, 32'h5000, 4'd7);
    for (int i = 0; i < 5; i++) push_beat(32'h700 + 32'(i), 4'hF);
    high = 0;
    for (int i = 0; i < 20; i++) begin
      if (AWVALID) high++;
      tick();
    end
    check("t2_aw_hold", high, 0);
    for (int i = 5; i < 8; i++) push_beat(32'h700 + 32'(i), 4'hF);
    check("t2_aw_after", AWVALID, 1);
    wait_resp(r0 + 1, "t2_resp_timeout");

    // Outstanding limit
    r0 = resp_log.size(); w0 = w_log.size(); a0 = aw_log.size();
    b_budget = 0;
    b_resp_val = 2'd1;
    for (int i = 1; i <= 5; i++) push_cmd(4'(i), 32'h6000 + 32'(i * 4), 4'd0);
    for (int i = 1; i <= 5; i++) push_beat(32'h600 + 32'(i), 4'hF);
    repeat (30) tick();
    check("t3_aw_count", aw_log.size() - a0, 4);
    check("t3_aw_blocked", AWVALID, 0);
    check("t3_w_count", w_log.size() - w0, 4);
    b_budget = 1;
    n = 0;
    while (aw_log.size() - a0 < 5 && n < 40) begin tick(); n++; end
    check("t3_fifth_aw", aw_log.size() - a0, 5);
    check("t3_aw_after_b", aw_hs_cyc - b_hs_cyc, 1);
    check("t3_fifth_id", aw_log[a0+4].id, 4'd5);
    b_budget = 1000;
    wait_resp(r0 + 5, "t3_resp_timeout");
    for (int i = 0; i < 5; i++) check("t3_resp", resp_log[r0+i], {4'(i + 1), 2'd1});

    // Random backpressure on AW and W
    r0 = resp_log.size(); w0 = w_log.size(); a0 = aw_log.size();
    aw_mode = 1; w_mode = 1;
    b_resp_val = 2'd0;
    push_cmd(4'd2, 32'h100, 4'd2);
    push_cmd(4'd4, 32'h200, 4'd5);
    push_cmd(4'd6, 32'h300, 4'd1);
    for (int i = 0; i < 11; i++) push_beat(32'hD00 + 32'(i), 4'hF);
    wait_resp(r0 + 3, "t4_resp_timeout");
    aw_mode = 0; w_mode = 0;
    check("t4_beats", w_log.size() - w0, 11);
    for (int i = 0; i < 11 && (w0 + i) < w_log.size(); i++) begin
      exp_data = 32'hD00 + 32'(i);
      check("t4_beat", {w_log[w0+i].id, w_log[w0+i].last, w_log[w0+i].data},
            {(i < 3) ? 4'd2 : (i < 9) ? 4'd4 : 4'd6, (i == 2 || i == 8 || i == 10), exp_data});
    end
    check("t4_aw_order", {aw_log[a0].id, aw_log[a0+1].id, aw_log[a0+2].id}, {4'd2, 4'd4, 4'd6});

    // Stray BVALID with nothing outstanding
    r0 = resp_log.size();
    b_force = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("stray_bready", BREADY, 0);
      tick();
    end
    b_force = 1'b0;
    tick();
    check("stray_no_resp", resp_log.size() - r0, 0);

    // Data FIFO full boundary
    aw_mode = 2;
    for (int i = 0; i < 64; i++) push_beat(32'hE00 + 32'(i), 4'hF);
    check("t5_full", wd_ready, 0);
    push_cmd(4'd1, 32'h0, 4'd0);
    w0 = w_log.size();
    aw_mode = 0;
    n = 0;
    while (w_log.size() == w0 && n < 50) begin tick(); n++; end
    check("t5_ready_after_pop", wd_ready, 1);
    check("t5_pop_data", w_log[w_log.size()-1].data, 32'hE00);

    ARESETn = 1'b0;
    repeat (2) tick();
    ARESETn = 1'b1;
    tick();
    check("t5_rst_ready", {cmd_ready, wd_ready, WVALID}, 3'b110);

    // Reset in the middle of a burst
    w0 = w_log.size();
    w_budget = 2;
    b_resp_val = 2'd0;
    push_cmd(4'hA, 32'h800, 4'd3);
    for (int i = 0; i < 4; i++) push_beat(32'hB0 + 32'(i), 4'hF);
    n = 0;
    while (w_log.size() - w0 < 2 && n < 40) begin tick(); n++; end
    check("t6_two_beats", w_log.size() - w0, 2);
    ARESETn = 1'b0;
    tick();
    check("t6_rst_valids", {AWVALID, WVALID, WLAST, BREADY}, 4'b0000);
    check("t6_rst_resp", {resp_valid, resp_id, resp_code}, 0);
    check("t6_rst_ready", {cmd_ready, wd_ready}, 2'b11);
    ARESETn = 1'b1;
    w_budget = 1000;
    tick();
    check("t6_post_idle", {AWVALID, WVALID}, 2'b00);
    r0 = resp_log.size();
    push_cmd(4'd6, 32'h900, 4'd0);
    push_beat(32'h77, 4'h3);
    wait_resp(r0 + 1, "t6_resp_timeout");
    check("t6_fresh_beat", {w_log[w_log.size()-1].id, w_log[w_log.size()-1].data}, {4'd6, 32'h77});
    check("t6_fresh_resp", resp_log[r0], {4'd6, 2'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
